// File: rtl/app_tl_tx_req_queue_if.sv
// Signal bundle between the application, the TLP header encoder and app_tl_tx_req_queue.
// slave = queue side, master = application/encoder side.
interface app_tl_tx_req_queue_if #(
    parameter int DEPTH   = 4,
    parameter int DATA_DW = 4
);
    localparam int AW = (DATA_DW > 1) ? $clog2(DATA_DW) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   req_valid, req_ready;
    logic [2:0]             req_kind;
    logic                   req_addr64, req_write, req_cfg_type;
    logic [15:0]            req_device_id, req_requester_id, req_dest_bdf;
    logic [7:0]             req_tag;
    logic [11:0]            req_byte_count;
    logic [63:0]            req_addr;
    logic [32*DATA_DW-1:0]  req_data;
    logic [9:0]             req_cfg_dw;
    logic [2:0]             req_cpl_status;
    logic [7:0]             req_msg_code;
    logic                   fsm_started, fsm_finished;
    logic [AW-1:0]          data_address;
    logic [2:0]             fmt_reg;
    logic [4:0]             type_reg;
    logic [7:0]             tag_reg;
    logic [15:0]            device_id_reg, requester_id_reg, dest_bdf_id_reg;
    logic [11:0]            byte_count_reg;
    logic [31:0]            lower_addr_reg, upper_addr_reg, data_reg;
    logic [9:0]             config_dw_number_reg;
    logic [2:0]             completion_status_reg;
    logic [7:0]             message_code_reg;
    logic                   valid_reg;
    logic                   cpl_rx_valid;
    logic [7:0]             cpl_rx_tag;
    logic                   tag_err;
    logic [CW-1:0]          q_count;

    modport slave (
        input  req_valid, req_kind, req_addr64, req_write, req_cfg_type,
               req_device_id, req_requester_id, req_dest_bdf, req_tag, req_byte_count,
               req_addr, req_data, req_cfg_dw, req_cpl_status, req_msg_code,
               fsm_started, fsm_finished, data_address, cpl_rx_valid, cpl_rx_tag,
        output req_ready, fmt_reg, type_reg, tag_reg, device_id_reg, requester_id_reg,
               dest_bdf_id_reg, byte_count_reg, lower_addr_reg, upper_addr_reg,
               config_dw_number_reg, completion_status_reg, message_code_reg,
               data_reg, valid_reg, tag_err, q_count
    );

    modport master (
        output req_valid, req_kind, req_addr64, req_write, req_cfg_type,
               req_device_id, req_requester_id, req_dest_bdf, req_tag, req_byte_count,
               req_addr, req_data, req_cfg_dw, req_cpl_status, req_msg_code,
               fsm_started, fsm_finished, data_address, cpl_rx_valid, cpl_rx_tag,
        input  req_ready, fmt_reg, type_reg, tag_reg, device_id_reg, requester_id_reg,
               dest_bdf_id_reg, byte_count_reg, lower_addr_reg, upper_addr_reg,
               config_dw_number_reg, completion_status_reg, message_code_reg,
               data_reg, valid_reg, tag_err, q_count
    );
endinterface

// File: rtl/app_tl_tx_req_queue.sv
// TX request queue: builds fmt/type/tag at enqueue, FIFOs requests, presents the head to the encoder.
// Macro APP_TL_TX_TAG_POOL_EN selects a free-bitmap tag pool instead of the rolling tag counter.
module app_tl_tx_req_queue #(
    parameter int DEPTH   = 4,
    parameter int DATA_DW = 4,
    parameter int TAG_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    app_tl_tx_req_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [2:0]               fmt;
        logic [4:0]               typ;
        logic [7:0]               tag;
        logic [15:0]              dev_id;
        logic [15:0]              req_id;
        logic [15:0]              dest_bdf;
        logic [11:0]              byte_count;
        logic [63:0]              addr;
        logic [9:0]               cfg_dw;
        logic [2:0]               cpl_status;
        logic [7:0]               msg_code;
        logic [DATA_DW-1:0][31:0] data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_BUSY} state_t;

    entry_t           r_mem [DEPTH];
    entry_t           r_head;
    entry_t           w_new;
    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_kind_ok, w_np, w_push, w_pop, w_tag_avail;
    logic [TAG_W-1:0] w_tag;

    // Non-posted: memory read, io, config. Kinds 5..7 are never accepted.
    assign w_kind_ok = (bus.req_kind <= 3'd4);
    assign w_np      = ((bus.req_kind == 3'd0) && !bus.req_write) ||
                       (bus.req_kind == 3'd1) || (bus.req_kind == 3'd4);
    assign bus.req_ready = rst && (r_cnt < CW'(DEPTH)) && w_kind_ok && (!w_np || w_tag_avail);
    assign w_push    = bus.req_valid && bus.req_ready;

    always_comb begin
        w_new            = '0;
        w_new.fmt        = {1'b0, bus.req_write, (bus.req_kind == 3'd0) && bus.req_addr64};
        case (bus.req_kind)
            3'd1:    w_new.typ = 5'b00010;
            3'd2:    w_new.typ = 5'b10010;
            3'd3:    w_new.typ = 5'b01010;
            3'd4:    w_new.typ = {4'b0010, bus.req_cfg_type};
            default: w_new.typ = 5'b00000;
        endcase
        if (bus.req_kind == 3'd3) w_new.tag = bus.req_tag;
        else if (w_np)            w_new.tag = 8'(w_tag);
        w_new.dev_id     = bus.req_device_id;
        w_new.req_id     = bus.req_requester_id;
        w_new.dest_bdf   = bus.req_dest_bdf;
        w_new.byte_count = bus.req_byte_count;
        w_new.addr       = bus.req_addr;
        w_new.cfg_dw     = bus.req_cfg_dw;
        w_new.cpl_status = bus.req_cpl_status;
        w_new.msg_code   = bus.req_msg_code;
        w_new.data       = bus.req_data;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_new;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE:    if (r_cnt != '0) begin
                           w_pop       = 1'b1;
                           w_state_nxt = S_PRESENT;
                       end
            S_PRESENT: if (bus.fsm_started)  w_state_nxt = S_BUSY;
            S_BUSY:    if (bus.fsm_finished) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_head  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_head <= r_mem[r_rd];
            end
        end
    end

    assign bus.q_count               = r_cnt;
    assign bus.valid_reg             = (r_state == S_PRESENT);
    assign bus.fmt_reg               = r_head.fmt;
    assign bus.type_reg              = r_head.typ;
    assign bus.tag_reg               = r_head.tag;
    assign bus.device_id_reg         = r_head.dev_id;
    assign bus.requester_id_reg      = r_head.req_id;
    assign bus.dest_bdf_id_reg       = r_head.dest_bdf;
    assign bus.byte_count_reg        = r_head.byte_count;
    assign bus.lower_addr_reg        = r_head.addr[31:0];
    assign bus.upper_addr_reg        = r_head.addr[63:32];
    assign bus.config_dw_number_reg  = r_head.cfg_dw;
    assign bus.completion_status_reg = r_head.cpl_status;
    assign bus.message_code_reg      = r_head.msg_code;

    always_comb begin
        bus.data_reg = '0;
        if (32'(bus.data_address) < DATA_DW) bus.data_reg = r_head.data[bus.data_address];
    end

`ifdef APP_TL_TX_TAG_POOL_EN
    localparam int NT = 2**TAG_W;
    logic [NT-1:0] r_free;
    logic          r_tag_err, w_oor, w_rel_bad;

    // Lowest-numbered free tag wins.
    always_comb begin
        w_tag       = '0;
        w_tag_avail = 1'b0;
        for (int i = NT-1; i >= 0; i--) begin
            if (r_free[i]) begin
                w_tag       = i[TAG_W-1:0];
                w_tag_avail = 1'b1;
            end
        end
    end

    assign w_oor     = ((bus.cpl_rx_tag >> TAG_W) != 8'd0);
    assign w_rel_bad = w_oor || r_free[bus.cpl_rx_tag[TAG_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_free    <= '1;
            r_tag_err <= 1'b0;
        end else begin
            r_tag_err <= bus.cpl_rx_valid && w_rel_bad;
            if (bus.cpl_rx_valid && !w_rel_bad) r_free[bus.cpl_rx_tag[TAG_W-1:0]] <= 1'b1;
            if (w_push && w_np) r_free[w_tag] <= 1'b0;
        end
    end

    assign bus.tag_err = r_tag_err;
`else
    logic [TAG_W-1:0] r_tag_cnt;
    wire              w_unused_cpl = &{1'b0, bus.cpl_rx_valid, bus.cpl_rx_tag};

    assign w_tag       = r_tag_cnt;
    assign w_tag_avail = 1'b1;
    assign bus.tag_err = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               r_tag_cnt <= '0;
        else if (w_push && w_np) r_tag_cnt <= r_tag_cnt + 1'b1;
    end
`endif
endmodule
